// File: rtl/ex_stage_ctrl.sv
// Execute-stage pipeline controller: operand-forward selects, load-use/RAW stalls,
// taken-branch squash and multi-cycle EX sequencing. Optional macro: EX_CTRL_FWD_EN.
module ex_stage_ctrl #(
   parameter int MultiCycles = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       id_valid,
   input  logic [4:0] id_rs1n,
   input  logic [4:0] id_rs2n,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic       id_multi,
   input  logic [4:0] ex_rdn,
   input  logic       ex_reg_write,
   input  logic       ex_is_load,
   input  logic       ex_branch_taken,
   input  logic [4:0] mem_rdn,
   input  logic       mem_reg_write,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       stall_if,
   output logic       stall_id,
   output logic       bubble_ex,
   output logic       hold_ex,
   output logic       flush_id,
   output logic       ex_busy
);

   typedef enum logic {RUN, MULTI} state_t;

   localparam logic [3:0] CntInit = 4'(MultiCycles - 1);
   localparam bit         MultiEn = (MultiCycles >= 2);

   state_t     r_state;
   logic [3:0] r_cnt;

   logic       w_run;
   logic       w_ex_a, w_ex_b, w_mem_a, w_mem_b;
   logic       w_load_use;
   logic       w_hazard;
   logic       w_branch;
   logic       w_stall;
   logic       w_issue;
   logic [1:0] w_fwd_a, w_fwd_b;

   assign w_run = (r_state == RUN);

   // Register 0 is hard-wired, so a zero destination never matches.
   assign w_ex_a  = id_use_rs1 && ex_reg_write  && (ex_rdn  == id_rs1n) && (ex_rdn  != 5'd0);
   assign w_ex_b  = id_use_rs2 && ex_reg_write  && (ex_rdn  == id_rs2n) && (ex_rdn  != 5'd0);
   assign w_mem_a = id_use_rs1 && mem_reg_write && (mem_rdn == id_rs1n) && (mem_rdn != 5'd0);
   assign w_mem_b = id_use_rs2 && mem_reg_write && (mem_rdn == id_rs2n) && (mem_rdn != 5'd0);

   assign w_load_use = id_valid && ex_is_load && (w_ex_a || w_ex_b);

`ifdef EX_CTRL_FWD_EN
   assign w_hazard = w_load_use;
   assign w_fwd_a  = w_ex_a ? 2'b01 : (w_mem_a ? 2'b10 : 2'b00);
   assign w_fwd_b  = w_ex_b ? 2'b01 : (w_mem_b ? 2'b10 : 2'b00);
`else
   // No bypass paths: every RAW dependency waits until the producer retires.
   assign w_hazard = w_load_use || (id_valid && (w_ex_a || w_ex_b || w_mem_a || w_mem_b));
   assign w_fwd_a  = 2'b00;
   assign w_fwd_b  = 2'b00;
`endif

   assign w_branch = w_run && ex_branch_taken;
   assign w_stall  = w_run && w_hazard && !ex_branch_taken;
   assign w_issue  = MultiEn && w_run && id_valid && id_multi && !w_hazard && !ex_branch_taken;

   always_comb begin
      fwd_a     = 2'b00;
      fwd_b     = 2'b00;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      if (w_run) begin
         fwd_a     = w_fwd_a;
         fwd_b     = w_fwd_b;
         stall_if  = w_stall;
         stall_id  = w_stall;
         bubble_ex = w_stall || w_branch;
         flush_id  = w_branch;
      end else begin
         stall_if = 1'b1;
         stall_id = 1'b1;
      end
   end

   assign hold_ex = !w_run;
   assign ex_busy = !w_run;

   // cnt counts the remaining EX cycles after the issue edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= RUN;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_issue) begin
                  r_state <= MULTI;
                  r_cnt   <= CntInit;
               end
            end
            MULTI: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) r_state <= RUN;
            end
            default: begin
               r_state <= RUN;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed testbench for ex_stage_ctrl; expectations follow EX_CTRL_FWD_EN when defined.
module tb_ex_stage_ctrl;

`ifdef EX_CTRL_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn;
   logic       id_valid, id_use_rs1, id_use_rs2, id_multi;
   logic [4:0] id_rs1n, id_rs2n, ex_rdn, mem_rdn;
   logic       ex_reg_write, ex_is_load, ex_branch_taken, mem_reg_write;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_if, stall_id, bubble_ex, hold_ex, flush_id, ex_busy;
   logic [1:0] d1_fwd_a, d1_fwd_b;
   logic       d1_stall_if, d1_stall_id, d1_bubble_ex, d1_hold_ex, d1_flush_id, d1_ex_busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_stage_ctrl #(.MultiCycles(4)) u_dut (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1n(id_rs1n), .id_rs2n(id_rs2n),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_multi(id_multi),
      .ex_rdn(ex_rdn), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
      .ex_branch_taken(ex_branch_taken), .mem_rdn(mem_rdn), .mem_reg_write(mem_reg_write),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if), .stall_id(stall_id),
      .bubble_ex(bubble_ex), .hold_ex(hold_ex), .flush_id(flush_id), .ex_busy(ex_busy)
   );

   ex_stage_ctrl #(.MultiCycles(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1n(id_rs1n), .id_rs2n(id_rs2n),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_multi(id_multi),
      .ex_rdn(ex_rdn), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
      .ex_branch_taken(ex_branch_taken), .mem_rdn(mem_rdn), .mem_reg_write(mem_reg_write),
      .fwd_a(d1_fwd_a), .fwd_b(d1_fwd_b), .stall_if(d1_stall_if), .stall_id(d1_stall_id),
      .bubble_ex(d1_bubble_ex), .hold_ex(d1_hold_ex), .flush_id(d1_flush_id), .ex_busy(d1_ex_busy)
   );

   // Bit order: fwd_a[1:0] fwd_b[1:0] stall_if stall_id bubble_ex hold_ex flush_id ex_busy
   task automatic chk(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = {fwd_a, fwd_b, stall_if, stall_id, bubble_ex, hold_ex, flush_id, ex_busy};
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      $display("check %-10s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = {d1_fwd_a, d1_fwd_b, d1_stall_if, d1_stall_id, d1_bubble_ex, d1_hold_ex,
             d1_flush_id, d1_ex_busy};
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      $display("check %-10s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic clr();
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_multi = 0;
      id_rs1n = 0; id_rs2n = 0; ex_rdn = 0; mem_rdn = 0;
      ex_reg_write = 0; ex_is_load = 0; ex_branch_taken = 0; mem_reg_write = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      clr();
      #3 chk("reset", 10'b0);
      #9 rstn = 1'b1;
      step();

      // Forwarding priority and register-0 exclusion
      clr(); id_valid = 1; id_use_rs1 = 1; id_rs1n = 5;
      ex_rdn = 5; ex_reg_write = 1; mem_rdn = 5; mem_reg_write = 1;
      #1 chk("fwd_ex", FWD ? 10'b01_00_000000 : 10'b00_00_111000);
      ex_reg_write = 0;
      #1 chk("fwd_mem", FWD ? 10'b10_00_000000 : 10'b00_00_111000);
      id_rs1n = 0;
      #1 chk("fwd_r0", 10'b0);
      id_rs1n = 5; id_use_rs1 = 0; ex_reg_write = 1;
      #1 chk("fwd_unused", 10'b0);
      clr(); id_valid = 1; id_use_rs2 = 1; id_rs2n = 9; ex_rdn = 9; ex_reg_write = 1;
      #1 chk("fwd_b_ex", FWD ? 10'b00_01_000000 : 10'b00_00_111000);

      // Load-use: one stall cycle, then MEM forward
      step();
      clr(); id_valid = 1; id_use_rs2 = 1; id_rs2n = 3;
      ex_is_load = 1; ex_reg_write = 1; ex_rdn = 3;
      #1 chk("ld_use", FWD ? 10'b00_01_111000 : 10'b00_00_111000);
      step();
      ex_is_load = 0; ex_reg_write = 0; ex_rdn = 0; mem_rdn = 3; mem_reg_write = 1;
      #1 chk("ld_next", FWD ? 10'b00_10_000000 : 10'b00_00_111000);

      // MEM-stage RAW clears once MEM retires
      step();
      clr(); id_valid = 1; id_use_rs1 = 1; id_rs1n = 7; mem_rdn = 7; mem_reg_write = 1;
      #1 chk("mem_raw", FWD ? 10'b10_00_000000 : 10'b00_00_111000);
      step();
      mem_reg_write = 0;
      #1 chk("mem_clr", 10'b0);

      // Multi-cycle: three hold cycles, inputs ignored while busy
      step();
      clr(); id_valid = 1; id_multi = 1;
      #1 chk("mul_iss", 10'b0);
      step();
      ex_branch_taken = 1; id_use_rs1 = 1; id_rs1n = 5; ex_rdn = 5; ex_reg_write = 1;
      #1 chk("mul_c1", 10'b00_00_110101);
      chk1("d1_nobusy", FWD ? 10'b01_00_001010 : 10'b00_00_001010);
      step();
      #1 chk("mul_c2", 10'b00_00_110101);
      step();
      #1 chk("mul_c3", 10'b00_00_110101);
      step();
      clr();
      #1 chk("mul_done", 10'b0);
      id_valid = 1; id_multi = 1;
      #1 chk("mul_reiss", 10'b0);
      step();
      clr();
      #1 chk("mul_again", 10'b00_00_110101);
      step(); step(); step();
      #1 chk("mul_drain", 10'b0);

      // Taken branch beats load-use and multi issue
      clr(); id_valid = 1; id_multi = 1; id_use_rs2 = 1; id_rs2n = 3;
      ex_is_load = 1; ex_reg_write = 1; ex_rdn = 3; ex_branch_taken = 1;
      #1 chk("br_win", FWD ? 10'b00_01_001010 : 10'b00_00_001010);
      step();
      clr();
      #1 chk("br_run", 10'b0);

      // Load-use beats multi issue; issue retried next cycle
      clr(); id_valid = 1; id_multi = 1; id_use_rs1 = 1; id_rs1n = 4;
      ex_is_load = 1; ex_reg_write = 1; ex_rdn = 4;
      #1 chk("lu_multi", FWD ? 10'b01_00_111000 : 10'b00_00_111000);
      step();
      ex_is_load = 0; ex_reg_write = 0; ex_rdn = 0;
      #1 chk("lu_retry", 10'b0);
      step();
      clr();
      #1 chk("lu_iss", 10'b00_00_110101);
      step(); step(); step();

      // Asynchronous reset in the middle of a multi op
      clr(); id_valid = 1; id_multi = 1;
      step();
      clr();
      step();
      #1 chk("rst_pre", 10'b00_00_110101);
      #1 rstn = 1'b0;
      #1 chk("rst_async", 10'b0);
      #2 rstn = 1'b1;
      id_valid = 1; id_multi = 1;
      #1 chk("rst_run", 10'b0);
      step();
      clr();
      #1 chk("rst_h1", 10'b00_00_110101);
      step();
      #1 chk("rst_h2", 10'b00_00_110101);
      step();
      #1 chk("rst_h3", 10'b00_00_110101);
      step();
      #1 chk("rst_h4", 10'b0);
      chk1("d1_idle", 10'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ex_stage_ctrl.md
# ex_stage_ctrl

Pipeline controller for the execute stage. It sits beside the ID/EX latch and ALU. It produces the operand-forwarding selects that feed the ID/EX latch, and it detects load-use and RAW hazards. It sequences multi-cycle EX operations by holding the ID/EX latch, and it squashes the wrong-path instruction when a branch resolves taken in EX.

## Interface
Parameters:
- MultiCycles, 4, total EX occupancy in cycles of an instruction flagged multi-cycle; legal range 1–15

Ports:
- clk  in  1  pipeline clock
- rstn  in  1  reset, asynchronous, active-low
- id_valid  in  1  valid instruction in ID
- id_rs1n, id_rs2n  in  5  ID source register numbers
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2
- id_multi  in  1  ID instruction needs MultiCycles in EX
- ex_rdn  in  5  destination of instruction in EX
- ex_reg_write  in  1  EX instruction writes rdn
- ex_is_load  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_rdn  in  5  destination of instruction in MEM
- mem_reg_write  in  1  MEM instruction writes rdn
- fwd_a, fwd_b  out  2  operand source for rs1 / rs2: 00 register file, 01 EX result (alu_out), 10 MEM result, 11 unused
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID latch
- bubble_ex  out  1  load NOP into ID/EX at next edge
- hold_ex  out  1  ID/EX latch keeps its contents
- flush_id  out  1  squash IF/ID contents
- ex_busy  out  1  multi-cycle op occupying EX

## Operation
- States: RUN, MULTI. Counter cnt has width 4.
- Register 0 never matches: no forwarding, no hazard.
- Forwarding (RUN, combinational) for each source:
  - 01 if ex_reg_write and ex_rdn==rs and ex_rdn!=0.
  - Else 10 if mem_reg_write and mem_rdn==rs and mem_rdn!=0.
  - Else 00.
  - EX has priority over MEM.
  - Unused sources give 00.
- Load-use (RUN): id_valid, ex_is_load, ex_reg_write, and a used source matches ex_rdn≠0.
  - Response: stall_if=stall_id=bubble_ex=1 for that cycle only.
  - Next cycle the load is in MEM and fwd selects 10.
- Taken branch (RUN, ex_branch_taken=1):
  - flush_id=1 and bubble_ex=1.
  - stall_if=stall_id=0; the branch overrides load-use.
  - No multi issue.
- Multi issue: in RUN with id_valid, id_multi, no stall, no flush, and MultiCycles≥2.
  - At the edge, state goes to MULTI and cnt loads MultiCycles-1.
- MULTI:
  - stall_if=stall_id=hold_ex=ex_busy=1, bubble_ex=flush_id=0.
  - fwd_a/fwd_b=00.
  - ex_branch_taken is ignored.
  - cnt decrements each edge; when cnt==1 at an edge, state returns to RUN.
- MultiCycles==1: never enters MULTI; id_multi is ignored.

## Timing
- Forwarding, stall, bubble and flush outputs are combinational from inputs and state; no added latency.
- ex_busy and hold_ex depend on state only and are registered-state derived.
- Multi op entering ID/EX at edge E occupies EX for cycles E..E+MultiCycles-1. The next instruction enters EX at edge E+MultiCycles.
- Reset (asynchronous, any time including mid-MULTI): state RUN, cnt 0.
  - ex_busy=hold_ex=0.
  - With all inputs 0, every output is 0.
- Simultaneous taken branch and multi issue: the branch wins; the multi instruction is flushed and no MULTI entry occurs.
- Simultaneous load-use and multi issue: stall wins; issue is retried next cycle.

## Configuration
- EX_CTRL_FWD_EN defined: forwarding as above; only load-use stalls.
- EX_CTRL_FWD_EN undefined:
  - fwd_a=fwd_b=00 always.
  - Any used source matching a writing ex_rdn or mem_rdn (≠0) stalls: stall_if=stall_id=bubble_ex=1.
  - The stall repeats each cycle until no match.
  - Branch priority and MULTI behaviour are unchanged.

## Test plan
- Forwarding: ex_rdn=5 with ex_reg_write, mem_rdn=5 with mem_reg_write, id_rs1n=5 used -> fwd_a=01. Drop ex_reg_write -> fwd_a=10. id_rs1n=0 -> fwd_a=00.
- Load-use: ex_is_load, ex_rdn=3, id_rs2n=3 used -> one cycle of stall_if=stall_id=bubble_ex=1. Next cycle with mem_rdn=3 -> fwd_b=10, no stall.
- Multi: MultiCycles=4, issue id_multi -> hold_ex=ex_busy=1 for exactly 3 cycles, then RUN and a new issue is accepted.
- Branch: ex_branch_taken with a load-use and id_multi present -> flush_id=bubble_ex=1, stall_if=0, state remains RUN.
- Reset mid-MULTI: deassert rstn with cnt=2 -> ex_busy=0 immediately. After release, state is RUN and a fresh multi issue gives the full 3 hold cycles.
- Without EX_CTRL_FWD_EN: mem_rdn=7 written, id_rs1n=7 used -> stall for 1 cycle until the MEM stage clears, fwd_a=00 throughout.
